wb_regfile_writer: RTL and testbench

Write-side controller for the 32x32 integer register file. It merges single-cycle ALU results and out-of-order-timed, in-order-returned load responses onto the file's single write port (WE3/A3/WD3). It keeps a busy scoreboard of destination registers with outstanding loads and produces a decode-stage stall for the two source operands. It sits between execute/memory and the register file and is the only driver of the write port.

---
 rtl/wb_regfile_writer_if.sv | 45 ++++
 rtl/wb_regfile_writer.sv | 179 +++++++++++++++++
 tb/tb_wb_regfile_writer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_writer_if.sv
// Bundle of bus signals between execute/memory and the register-file write-side controller.
// The master side drives results, loads and decode operands; the slave side is the controller.
interface wb_regfile_writer_if #(
  parameter int XLEN = 32
) ();
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_issue_valid;
  logic [4:0]      ld_issue_rd;
  logic            ld_issue_ready;

  logic            ld_resp_valid;
  logic [XLEN-1:0] ld_resp_data;
  logic            ld_resp_ready;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            stall;
  logic [31:0]     busy;

  logic            WE3;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;
  logic            err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd,
    output ld_resp_valid, ld_resp_data,
    output rs1, rs2,
    input  ld_issue_ready, ld_resp_ready, stall, busy,
    input  WE3, A3, WD3, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd,
    input  ld_resp_valid, ld_resp_data,
    input  rs1, rs2,
    output ld_issue_ready, ld_resp_ready, stall, busy,
    output WE3, A3, WD3, err
  );
endinterface

// File: rtl/wb_regfile_writer.sv
// Write-port arbiter for the 32x32 register file: merges ALU results and in-order load
// responses, tracks registers with outstanding loads and raises the decode stall.
module wb_regfile_writer #(
  parameter int XLEN      = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  wb_regfile_writer_if.slave   bus
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TAG_DEPTH - 1);

  // Tag FIFO holding destination registers of issued loads, oldest at rd_ptr.
  logic [4:0]       tag_mem_q [TAG_DEPTH];
  logic [4:0]       tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             skid_valid_q, skid_valid_d;
  logic [4:0]       skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]  skid_data_q, skid_data_d;

  logic             we_q, we_d;
  logic [4:0]       a3_q, a3_d;
  logic [XLEN-1:0]  wd3_q, wd3_d;
  logic             ld_wr_q, ld_wr_d;

  logic [31:0]      busy_q, busy_d;
  logic             err_q, err_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             issue_accept;
  logic             resp_accept;
  logic [4:0]       head_rd;

  logic             sel_valid;
  logic             sel_load;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign issue_accept = bus.ld_issue_valid & ~fifo_full;
  // A response arriving with no outstanding tag is dropped rather than accepted.
  assign resp_accept  = bus.ld_resp_valid & ~skid_valid_q & ~fifo_empty;
  assign head_rd      = tag_mem_q[rd_ptr_q];

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (issue_accept) begin
      tag_mem_d[wr_ptr_q] = bus.ld_issue_rd;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (resp_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({issue_accept, resp_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Fixed priority: ALU, then a parked response, then a fresh response.
  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
    end else if (skid_valid_q) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = skid_rd_q;
      sel_data  = skid_data_q;
    end else if (resp_accept) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = head_rd;
      sel_data  = bus.ld_resp_data;
    end
  end

  always_comb begin
    we_d    = sel_valid & (sel_rd != 5'd0);
    a3_d    = sel_rd;
    wd3_d   = sel_data;
    ld_wr_d = sel_load;
  end

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (resp_accept && bus.alu_valid) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = head_rd;
      skid_data_d  = bus.ld_resp_data;
    end else if (skid_valid_q && !bus.alu_valid) begin
      skid_valid_d = 1'b0;
    end
  end

  // Busy bit drops on the edge closing the load's WE3 cycle; a new issue to the
  // same register in that cycle keeps it set.
  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      assign busy_d[gi] = 1'b0;
    end else begin : g_xn
      logic set_bit;
      logic clr_bit;
      assign set_bit    = issue_accept && (bus.ld_issue_rd == 5'(gi));
      assign clr_bit    = ld_wr_q && (a3_q == 5'(gi));
      assign busy_d[gi] = set_bit | (busy_q[gi] & ~clr_bit);
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.ld_resp_valid && fifo_empty)        err_d = 1'b1;
    if (bus.alu_valid && busy_q[bus.alu_rd])    err_d = 1'b1;
    if (issue_accept && busy_q[bus.ld_issue_rd]) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      tag_mem_q    <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      we_q         <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      ld_wr_q      <= 1'b0;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      we_q         <= we_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      ld_wr_q      <= ld_wr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.ld_issue_ready = ~fifo_full;
  assign bus.ld_resp_ready  = ~skid_valid_q;
  assign bus.stall          = ((bus.rs1 != 5'd0) && busy_q[bus.rs1]) ||
                              ((bus.rs2 != 5'd0) && busy_q[bus.rs2]);
  assign bus.busy           = busy_q;
  assign bus.WE3            = we_q;
  assign bus.A3             = a3_q;
  assign bus.WD3            = wd3_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Directed bench for wb_regfile_writer: a behavioural write-order model feeds a scoreboard
// of expected register-file writes, plus point checks on timing, busy, stall and err.
module tb_wb_regfile_writer;

  localparam int XLEN      = 32;
  localparam int TAG_DEPTH = 4;

  logic clk;
  logic areset;

  wb_regfile_writer_if #(.XLEN(XLEN)) bus_if ();

  wb_regfile_writer #(.XLEN(XLEN), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writes {rd, data} in the order the register file must see them.
  logic [36:0] exp_q [$];
  // Model state: outstanding load tags and accepted-but-unwritten load results.
  logic [4:0]  m_tags  [$];
  logic [36:0] m_defer [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Applies the next clock edge to the model using the inputs currently driven.
  task automatic model_step();
    int          pre;
    logic [4:0]  rd;
    logic [36:0] w;
    if (!areset) begin
      m_tags.delete();
      m_defer.delete();
      return;
    end
    pre = m_tags.size();
    if (bus_if.ld_resp_valid && m_defer.size() == 0 && pre > 0) begin
      rd = m_tags.pop_front();
      m_defer.push_back({rd, bus_if.ld_resp_data});
    end
    if (bus_if.ld_issue_valid && pre < TAG_DEPTH) m_tags.push_back(bus_if.ld_issue_rd);
    if (bus_if.alu_valid) begin
      if (bus_if.alu_rd != 5'd0) exp_q.push_back({bus_if.alu_rd, bus_if.alu_data});
    end else if (m_defer.size() > 0) begin
      w = m_defer.pop_front();
      if (w[36:32] != 5'd0) exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    logic [36:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (bus_if.WE3) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {27'd0, bus_if.A3, bus_if.WD3}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", {27'd0, bus_if.A3, bus_if.WD3}, {27'd0, e});
        $display("write rd=%0d data=0x%08h", bus_if.A3, bus_if.WD3);
      end
    end
  endtask

  task automatic idle_inputs();
    bus_if.alu_valid      = 1'b0;
    bus_if.alu_rd         = '0;
    bus_if.alu_data       = '0;
    bus_if.ld_issue_valid = 1'b0;
    bus_if.ld_issue_rd    = '0;
    bus_if.ld_resp_valid  = 1'b0;
    bus_if.ld_resp_data   = '0;
  endtask

  initial begin
    areset = 1'b0;
    idle_inputs();
    bus_if.rs1 = '0;
    bus_if.rs2 = '0;

    // Reset with random activity on every input.
    for (int i = 0; i < 2; i++) begin
      bus_if.alu_valid      = 1'($urandom);
      bus_if.alu_rd         = 5'($urandom);
      bus_if.alu_data       = $urandom;
      bus_if.ld_issue_valid = 1'($urandom);
      bus_if.ld_issue_rd    = 5'($urandom);
      bus_if.ld_resp_valid  = 1'($urandom);
      bus_if.ld_resp_data   = $urandom;
      bus_if.rs1            = 5'($urandom);
      bus_if.rs2            = 5'($urandom);
      tick();
    end
    check("rst_we3", bus_if.WE3, 0);
    check("rst_a3", bus_if.A3, 0);
    check("rst_wd3", bus_if.WD3, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_err", bus_if.err, 0);
    check("rst_issue_ready", bus_if.ld_issue_ready, 1);
    check("rst_resp_ready", bus_if.ld_resp_ready, 1);
    check("rst_stall", bus_if.stall, 0);
    idle_inputs();
    bus_if.rs1 = '0;
    bus_if.rs2 = '0;
    areset = 1'b1;
    tick();
    check("idle_we3", bus_if.WE3, 0);

    // ALU only.
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd5; bus_if.alu_data = 32'h1234_5678;
    tick();
    check("alu_we3", bus_if.WE3, 1);
    check("alu_a3", bus_if.A3, 5);
    check("alu_wd3", bus_if.WD3, 32'h1234_5678);
    bus_if.alu_rd = 5'd0; bus_if.alu_data = 32'hAAAA_5555;
    tick();
    check("alu_x0_we3", bus_if.WE3, 0);
    idle_inputs();

    // Load round trip.
    bus_if.ld_issue_valid = 1'b1; bus_if.ld_issue_rd = 5'd7; bus_if.rs1 = 5'd7;
    tick();
    bus_if.ld_issue_valid = 1'b0;
    check("ld_busy7_set", bus_if.busy[7], 1);
    check("ld_stall_set", bus_if.stall, 1);
    tick();
    tick();
    bus_if.ld_resp_valid = 1'b1; bus_if.ld_resp_data = 32'hDEAD_BEEF;
    tick();
    bus_if.ld_resp_valid = 1'b0;
    check("ld_we3", bus_if.WE3, 1);
    check("ld_a3", bus_if.A3, 7);
    check("ld_wd3", bus_if.WD3, 32'hDEAD_BEEF);
    check("ld_busy7_held", bus_if.busy[7], 1);
    tick();
    check("ld_busy7_clr", bus_if.busy[7], 0);
    check("ld_stall_clr", bus_if.stall, 0);
    bus_if.rs1 = '0;

    // Collision: response parked while ALU owns the port for three cycles.
    bus_if.ld_issue_valid = 1'b1; bus_if.ld_issue_rd = 5'd9;
    tick();
    bus_if.ld_issue_valid = 1'b0;
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd3; bus_if.alu_data = 32'h0000_0033;
    bus_if.ld_resp_valid = 1'b1; bus_if.ld_resp_data = 32'h0000_0099;
    tick();
    bus_if.ld_resp_valid = 1'b0;
    check("col_a3_alu", bus_if.A3, 3);
    check("col_resp_ready", bus_if.ld_resp_ready, 0);
    bus_if.alu_rd = 5'd10; bus_if.alu_data = 32'h0000_0A0A;
    tick();
    check("col_a3_alu2", bus_if.A3, 10);
    check("col_resp_ready2", bus_if.ld_resp_ready, 0);
    bus_if.alu_rd = 5'd11; bus_if.alu_data = 32'h0000_0B0B;
    tick();
    check("col_a3_alu3", bus_if.A3, 11);
    bus_if.alu_valid = 1'b0;
    tick();
    check("col_we3_ld", bus_if.WE3, 1);
    check("col_a3_ld", bus_if.A3, 9);
    check("col_resp_ready_back", bus_if.ld_resp_ready, 1);
    check("col_busy9_held", bus_if.busy[9], 1);
    tick();
    check("col_busy9_clr", bus_if.busy[9], 0);
    check("col_err", bus_if.err, 0);

    // Fill the tag FIFO.
    for (int i = 1; i <= 4; i++) begin
      bus_if.ld_issue_valid = 1'b1; bus_if.ld_issue_rd = 5'(i);
      tick();
    end
    check("full_ready", bus_if.ld_issue_ready, 0);
    check("full_busy", bus_if.busy, 32'h0000_001E);
    bus_if.ld_issue_rd = 5'd6;
    tick();
    check("full_ignored_busy", bus_if.busy, 32'h0000_001E);
    check("full_ready_hold", bus_if.ld_issue_ready, 0);
    bus_if.ld_issue_valid = 1'b0;
    bus_if.ld_resp_valid = 1'b1; bus_if.ld_resp_data = 32'h0000_0101;
    tick();
    check("cnt3_ready", bus_if.ld_issue_ready, 1);
    bus_if.ld_issue_valid = 1'b1; bus_if.ld_issue_rd = 5'd5;
    bus_if.ld_resp_data = 32'h0000_0102;
    tick();
    bus_if.ld_issue_valid = 1'b0;
    check("pushpop_ready", bus_if.ld_issue_ready, 1);
    check("pushpop_busy", bus_if.busy, 32'h0000_003C);
    for (int i = 3; i <= 5; i++) begin
      bus_if.ld_resp_data = 32'h0000_0100 + 32'(i);
      tick();
    end
    bus_if.ld_resp_valid = 1'b0;
    tick();
    check("drain_busy", bus_if.busy, 0);

    // Pipelined issue/response pairs wrapping the FIFO pointers.
    for (int i = 0; i <= 10; i++) begin
      bus_if.ld_issue_valid = (i < 10);
      bus_if.ld_issue_rd    = 5'(16 + i);
      bus_if.ld_resp_valid  = (i > 0);
      bus_if.ld_resp_data   = 32'h0000_0200 + 32'(i);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    check("wrap_busy", bus_if.busy, 0);
    check("wrap_err", bus_if.err, 0);

    // Protocol violations.
    bus_if.ld_resp_valid = 1'b1; bus_if.ld_resp_data = 32'h0000_0BAD;
    tick();
    bus_if.ld_resp_valid = 1'b0;
    check("viol_empty_err", bus_if.err, 1);
    check("viol_empty_we3", bus_if.WE3, 0);
    bus_if.ld_issue_valid = 1'b1; bus_if.ld_issue_rd = 5'd4;
    tick();
    bus_if.ld_issue_valid = 1'b0;
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd4; bus_if.alu_data = 32'h0000_0044;
    tick();
    bus_if.alu_valid = 1'b0;
    check("viol_alu_we3", bus_if.WE3, 1);
    check("viol_alu_a3", bus_if.A3, 4);
    check("viol_alu_wd3", bus_if.WD3, 32'h0000_0044);
    tick();
    check("viol_busy4_kept", bus_if.busy[4], 1);
    tick();
    tick();
    check("viol_err_sticky", bus_if.err, 1);
    bus_if.ld_resp_valid = 1'b1; bus_if.ld_resp_data = 32'h0000_0404;
    tick();
    bus_if.ld_resp_valid = 1'b0;
    tick();
    check("viol_busy4_clr", bus_if.busy[4], 0);

    // Reset mid-operation discards the parked response.
    bus_if.ld_issue_valid = 1'b1; bus_if.ld_issue_rd = 5'd12;
    tick();
    bus_if.ld_issue_valid = 1'b0;
    bus_if.alu_valid = 1'b1; bus_if.alu_rd = 5'd13; bus_if.alu_data = 32'h0000_1313;
    bus_if.ld_resp_valid = 1'b1; bus_if.ld_resp_data = 32'h0000_000C;
    tick();
    check("mid_a3", bus_if.A3, 13);
    check("mid_resp_ready", bus_if.ld_resp_ready, 0);
    idle_inputs();
    areset = 1'b0;
    tick();
    check("mid_rst_we3", bus_if.WE3, 0);
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_err", bus_if.err, 0);
    check("mid_rst_resp_ready", bus_if.ld_resp_ready, 1);
    check("mid_rst_issue_ready", bus_if.ld_issue_ready, 1);
    areset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_we3", bus_if.WE3, 0);
    end
    check("sb_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
